// File: rtl/manch_rx_if.sv
// manch_rx_if: byte handshake between the Manchester receiver and its consumer.
interface manch_rx_if;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    modport master(output byte_out, output byte_valid, input byte_ready);
    modport slave(input byte_out, input byte_valid, output byte_ready);
endinterface

// File: rtl/manch_rx_ctrl.sv
// manch_rx_ctrl: oversampling Manchester receiver with preamble lock, byte assembly and frame supervision.
// Define MANCH_RX_GLITCH_EN to insert a 3-tap majority filter ahead of edge detection.
module manch_rx_ctrl #(
    parameter int OSR         = 16,
    parameter int SYNC_LEN    = 8,
    parameter int FRAME_BYTES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       datamin,
    manch_rx_if.master bus,
    output logic       frame_done,
    output logic       err,
    output logic       busy
);
    localparam int CW = $clog2(2 * OSR) + 1;
    localparam int OW = $clog2(SYNC_LEN + 1);
    localparam logic [CW-1:0] LO   = CW'(3 * OSR / 4);
    localparam logic [CW-1:0] TMO  = CW'(5 * OSR / 4 + 1);
    localparam logic [CW-1:0] CMAX = '1;
    localparam logic [OW-1:0] OMAX = OW'(SYNC_LEN);
    localparam logic [7:0]    LAST = 8'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {HUNT, SYNC, DATA} state_t;

    state_t        state, state_n;
    logic          s1, s2, line, prev, edge_det, bit_val, mid, tmo;
    logic          load, done_n, err_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [OW-1:0] ones, ones_n;
    logic [2:0]    bitc, bitc_n;
    logic [7:0]    bytec, bytec_n, sh, sh_n, nbyte;

`ifdef MANCH_RX_GLITCH_EN
    logic d1, d2;
    // Two delay taps so the line is the majority of three consecutive synced samples
    always_ff @(posedge clk) begin
        if (rst) begin
            d1 <= 1'b0;
            d2 <= 1'b0;
        end else begin
            d1 <= s2;
            d2 <= d1;
        end
    end
    assign line = (s2 & d1) | (s2 & d2) | (d1 & d2);
`else
    assign line = s2;
`endif

    // Metastability synchronizer plus previous-sample register for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= datamin;
            s2   <= s1;
            prev <= line;
        end
    end

    // A falling mid-bit edge (prev high) decodes as 1, a rising one as 0
    assign edge_det = line ^ prev;
    assign bit_val  = prev;
    assign mid      = edge_det && cnt >= LO;
    assign tmo      = cnt >= TMO;
    assign nbyte    = {bit_val, sh[7:1]};
    assign busy     = state == DATA;

    // Next-state, bit timing, preamble counting and byte assembly
    always_comb begin
        state_n = state;
        cnt_n   = cnt == CMAX ? cnt : cnt + 1'b1;
        ones_n  = ones;
        bitc_n  = bitc;
        bytec_n = bytec;
        sh_n    = sh;
        load    = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        if (!en) begin
            state_n = HUNT;
            cnt_n   = '0;
            ones_n  = '0;
            bitc_n  = '0;
            bytec_n = '0;
            sh_n    = '0;
        end else if (state == HUNT) begin
            if (edge_det) begin
                state_n = SYNC;
                cnt_n   = '0;
                ones_n  = '0;
            end
        end else if (tmo) begin
            state_n = HUNT;
            err_n   = state == DATA;
        end else if (mid) begin
            cnt_n = '0;
            if (state == SYNC) begin
                if (bit_val) begin
                    ones_n = ones >= OMAX ? ones : ones + 1'b1;
                end else if (ones >= OMAX) begin
                    state_n = DATA;
                    bitc_n  = '0;
                    bytec_n = '0;
                    sh_n    = '0;
                end else begin
                    state_n = HUNT;
                end
            end else begin
                sh_n   = nbyte;
                bitc_n = bitc + 1'b1;
                if (bitc == 3'd7) begin
                    if (bus.byte_valid && !bus.byte_ready) begin
                        err_n   = 1'b1;
                        state_n = HUNT;
                    end else begin
                        load    = 1'b1;
                        bytec_n = bytec + 1'b1;
                        if (bytec == LAST) begin
                            done_n  = 1'b1;
                            state_n = HUNT;
                        end
                    end
                end
            end
        end
    end

    // Control state register with the status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            cnt        <= '0;
            ones       <= '0;
            bitc       <= '0;
            bytec      <= '0;
            sh         <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            ones       <= ones_n;
            bitc       <= bitc_n;
            bytec      <= bytec_n;
            sh         <= sh_n;
            frame_done <= done_n;
            err        <= err_n;
        end
    end

    // Output holding register lives outside the FSM so a pending byte survives relocking
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.byte_out   <= '0;
            bus.byte_valid <= 1'b0;
        end else if (load) begin
            bus.byte_out   <= nbyte;
            bus.byte_valid <= 1'b1;
        end else if (bus.byte_valid && bus.byte_ready) begin
            bus.byte_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_manch_rx_ctrl.sv
// tb_manch_rx_ctrl: random and directed Manchester frames checked against a timestamp-based reference model.
module tb_manch_rx_ctrl;
    localparam int OSR = 16;
    localparam int SL  = 8;
    localparam int FB  = 2;
    localparam int HB  = OSR / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic datamin = 1'b0;
    logic frame_done, err, busy;
    manch_rx_if bus();

    manch_rx_ctrl #(.OSR(OSR), .SYNC_LEN(SL), .FRAME_BYTES(FB)) dut (
        .clk(clk), .rst(rst), .en(en), .datamin(datamin), .bus(bus),
        .frame_done(frame_done), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic smp [0:65535];
    int cyc = 8;
    logic started = 1'b0;
    logic t_rst = 1'b1, t_en = 1'b0, chaos = 1'b0, last_d = 1'b0;
    int rdy_mode = 0;

    int m_mode = 0, t_acc = 0, m_ones = 0, m_nbits = 0, m_acc = 0, m_nbytes = 0;
    logic [7:0] nx_out = 8'h00, cur_out = 8'h00;
    logic nx_valid = 0, nx_done = 0, nx_err = 0, nx_busy = 0;
    logic cur_valid = 0, cur_done = 0, cur_err = 0, cur_busy = 0;

    logic [7:0] got [$];
    int n_done, n_err, n_valid, n_busy;

    function automatic logic lv(input int k);
`ifdef MANCH_RX_GLITCH_EN
        return (int'(smp[k-1]) + int'(smp[k-2]) + int'(smp[k-3])) >= 2;
`else
        return smp[k-1];
`endif
    endfunction

    task automatic model_step();
        logic e, b, ld, dn, er;
        int age;
        smp[cyc+1] = datamin;
        e = lv(cyc) != lv(cyc - 1);
        b = lv(cyc - 1);
        age = cyc - t_acc - 1;
        ld = 0; dn = 0; er = 0;
        if (rst) begin
            for (int i = cyc - 3; i <= cyc + 1; i++) smp[i] = 1'b0;
            m_mode = 0;
            nx_valid = 0;
            nx_out = 8'h00;
        end else begin
            if (!en) m_mode = 0;
            else if (m_mode == 0) begin
                if (e) begin m_mode = 1; t_acc = cyc; m_ones = 0; end
            end else if (age >= 5 * OSR / 4 + 1) begin
                er = m_mode == 2;
                m_mode = 0;
            end else if (e && age >= 3 * OSR / 4) begin
                t_acc = cyc;
                if (m_mode == 1) begin
                    if (b) m_ones = m_ones < SL ? m_ones + 1 : m_ones;
                    else if (m_ones >= SL) begin m_mode = 2; m_nbits = 0; m_acc = 0; m_nbytes = 0; end
                    else m_mode = 0;
                end else begin
                    m_acc += int'(b) << m_nbits;
                    m_nbits++;
                    if (m_nbits == 8) begin
                        if (nx_valid && !bus.byte_ready) begin er = 1; m_mode = 0; end
                        else begin
                            ld = 1;
                            nx_out = 8'(m_acc);
                            m_nbytes++;
                            if (m_nbytes == FB) begin dn = 1; m_mode = 0; end
                        end
                        m_nbits = 0;
                        m_acc = 0;
                    end
                end
            end
            if (ld) nx_valid = 1;
            else if (nx_valid && bus.byte_ready) nx_valid = 0;
        end
        nx_done = dn;
        nx_err = er;
        nx_busy = m_mode == 2;
    endtask

    task automatic tick(input logic d);
        @(posedge clk);
        #1;
        cur_out = nx_out; cur_valid = nx_valid; cur_done = nx_done; cur_err = nx_err; cur_busy = nx_busy;
        started = 1'b1;
        rst = t_rst || (chaos && $urandom_range(0, 4999) == 0);
        en = t_en && !(chaos && $urandom_range(0, 799) == 0);
        bus.byte_ready = rdy_mode == 2 ? 1'($urandom_range(0, 1)) : rdy_mode == 1;
        datamin = d;
        last_d = d;
        model_step();
        cyc++;
    endtask

    task automatic send_bit(input logic b, input int jit, input int gl);
        int h1, h2;
        h1 = HB + (jit != 0 ? int'($urandom_range(0, 2)) - 1 : 0);
        h2 = HB + (jit != 0 ? int'($urandom_range(0, 2)) - 1 : 0);
        for (int k = 0; k < h1; k++) tick((k == 4 && gl > 0 && int'($urandom_range(0, 99)) < gl) ? ~b : b);
        for (int k = 0; k < h2; k++) tick(~b);
    endtask

    task automatic send_frame(input int npre, input logic [7:0] b0, input logic [7:0] b1,
                              input int nb, input logic idle, input int jit, input int gl);
        logic [15:0] w;
        w = {b1, b0};
        repeat (40) tick(idle);
        for (int i = 0; i < npre; i++) send_bit(1'b1, jit, 0);
        send_bit(1'b0, jit, 0);
        for (int i = 0; i < nb; i++) send_bit(w[i], jit, gl);
        repeat (40) tick(last_d);
    endtask

    task automatic clr();
        got.delete();
        n_done = 0; n_err = 0; n_valid = 0; n_busy = 0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model plus scenario statistics
    always @(negedge clk) begin
        if (started) begin
            checks++;
            if ({bus.byte_out, bus.byte_valid, frame_done, err, busy} !== {cur_out, cur_valid, cur_done, cur_err, cur_busy}) begin
                errors++;
                $display("FAIL cycle %0d outputs: got out=%h valid=%b done=%b err=%b busy=%b, expected out=%h valid=%b done=%b err=%b busy=%b",
                         cyc, bus.byte_out, bus.byte_valid, frame_done, err, busy, cur_out, cur_valid, cur_done, cur_err, cur_busy);
            end
            if (bus.byte_valid && bus.byte_ready) got.push_back(bus.byte_out);
            if (frame_done) n_done++;
            if (err) n_err++;
            if (bus.byte_valid) n_valid++;
            if (busy) n_busy++;
        end
    end

    initial begin
        foreach (smp[i]) smp[i] = 1'b0;
        bus.byte_ready = 1'b0;
        repeat (4) tick(1'b0);
        chk("reset byte_out", int'(bus.byte_out), 0);
        chk("reset byte_valid", int'(bus.byte_valid), 0);
        t_rst = 0; t_en = 1; rdy_mode = 1;

        clr();
        send_frame(10, 8'hA5, 8'h3C, 16, 1'b1, 0, 0);
        chk("basic byte count", got.size(), 2);
        chk("basic byte0", int'(got[0]), 'hA5);
        chk("basic byte1", int'(got[1]), 'h3C);
        chk("basic frame_done", n_done, 1);
        chk("basic err", n_err, 0);
        chk("basic busy end", int'(busy), 0);

        clr();
        send_frame(10, 8'hA5, 8'h3C, 4, 1'b1, 0, 0);
        chk("timeout err", n_err, 1);
        chk("timeout no valid", n_valid, 0);
        chk("timeout busy end", int'(busy), 0);

        clr();
        send_frame(10, 8'hA5, 8'h3C, 16, 1'b0, 0, 0);
        chk("relock byte count", got.size(), 2);
        chk("relock byte0", int'(got[0]), 'hA5);
        chk("relock byte1", int'(got[1]), 'h3C);
        chk("relock frame_done", n_done, 1);

        clr();
        send_frame(5, 8'hA5, 8'h3C, 16, 1'b1, 0, 0);
        chk("short preamble bytes", got.size(), 0);
        chk("short preamble err", n_err, 0);
        chk("short preamble busy", n_busy, 0);

        clr();
        rdy_mode = 0;
        send_frame(10, 8'hA5, 8'h3C, 16, 1'b1, 0, 0);
        chk("overflow err", n_err, 1);
        chk("overflow frame_done", n_done, 0);
        chk("overflow held byte", int'(bus.byte_out), 'hA5);
        chk("overflow held valid", int'(bus.byte_valid), 1);
        rdy_mode = 1;
        repeat (3) tick(last_d);
        chk("overflow drained", got.size(), 1);
        chk("overflow drained byte", int'(got[0]), 'hA5);

        clr();
        send_frame(10, 8'hA5, 8'h3C, 16, 1'b1, 0, 100);
`ifdef MANCH_RX_GLITCH_EN
        chk("glitch byte count", got.size(), 2);
        chk("glitch byte0", int'(got[0]), 'hA5);
        chk("glitch byte1", int'(got[1]), 'h3C);
        chk("glitch err", n_err, 0);
`else
        chk("glitch disturbs reception", int'(got.size() != 2 || got[0] != 8'hA5 || got[1] != 8'h3C || n_err != 0), 1);
`endif

        rdy_mode = 2;
        chaos = 1;
        for (int f = 0; f < 30; f++) begin
            send_frame(int'($urandom_range(3, 12)), 8'($urandom), 8'($urandom),
                       $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 16)) : 16,
                       1'($urandom_range(0, 1)), 1, 5);
        end
        chaos = 0;
        repeat (50) tick(last_d);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
